// File: rtl/cache_miss_sequencer.sv
// Miss sequencer for a 4-way tag array: tree pseudo-LRU per set, victim selection,
// line fetch from memory, data RAM fill steering and tag write-back.
module cache_miss_sequencer #(
    parameter int SET_BITS   = 11,
    parameter int BEATS_LOG2 = 3
) (
    input  logic                  main_clk,
    input  logic                  main_rst_n,
    input  logic                  lookup_valid,
    input  logic [30:0]           lookup_addr,
    input  logic                  lookup_no_access,
    input  logic                  tag_hard_fault,
    input  logic [1:0]            tag_hit_way,
    output logic                  stall,
    output logic [1:0]            way_index,
    output logic                  tag_write,
    output logic                  mem_req,
    output logic [21:0]           mem_line_addr,
    input  logic                  mem_ack,
    input  logic                  mem_data_valid,
    output logic                  fill_we,
    output logic [1:0]            fill_way,
    output logic [BEATS_LOG2-1:0] fill_beat,
    output logic [15:0]           miss_count
);

    localparam int DEPTH = 1 << SET_BITS;

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        IDLE   = 3'd1,
        CHECK  = 3'd2,
        REQ    = 3'd3,
        FILL   = 3'd4,
        TAGW   = 3'd5,
        SETTLE = 3'd6
    } state_t;

    // PLRU bits are {b2, b1, b0}: b0 picks the way pair, b1/b2 pick within pair 0-1 / 2-3.
    function automatic logic [1:0] plru_victim(input logic [2:0] p);
        logic [1:0] v;
        if (p[0]) begin
            v = p[2] ? 2'd3 : 2'd2;
        end else begin
            v = p[1] ? 2'd1 : 2'd0;
        end
        return v;
    endfunction

    function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
        logic [2:0] n;
        n    = p;
        n[0] = ~w[1];
        if (!w[1]) begin
            n[1] = ~w[0];
        end else begin
            n[2] = ~w[0];
        end
        return n;
    endfunction

    state_t                r_state;
    state_t                w_next_state;
    logic [SET_BITS-1:0]   r_sweep;
    logic [21:0]           r_line;
    logic                  r_no_access;
    logic [1:0]            r_way;
    logic [BEATS_LOG2-1:0] r_beat;
    logic                  r_settle;
    logic [15:0]           r_miss_count;
    logic [2:0]            r_plru [DEPTH];

    logic [SET_BITS-1:0]   w_set;
    logic [2:0]            w_plru_cur;
    logic                  w_fault;
    logic                  w_hit_upd;
    logic                  w_accept;
    logic                  w_stall;
    logic                  w_plru_we;
    logic [SET_BITS-1:0]   w_plru_waddr;
    logic [2:0]            w_plru_wdata;
    logic                  w_unused_addr;

    // Only address[25:4] matters; line offset and upper bits are dropped.
    assign w_unused_addr = ^{lookup_addr[30:26], lookup_addr[3:0]};

    assign w_set      = r_line[SET_BITS-1:0];
    assign w_plru_cur = r_plru[w_set];
    assign w_fault    = tag_hard_fault & ~r_no_access;
    assign w_hit_upd  = ~tag_hard_fault & ~r_no_access;

    // Next-state, stall and PLRU write-port decode.
    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_accept     = 1'b0;
        w_plru_we    = 1'b0;
        w_plru_waddr = w_set;
        w_plru_wdata = 3'b000;
        case (r_state)
            INIT: begin
                w_stall      = 1'b1;
                w_plru_we    = 1'b1;
                w_plru_waddr = r_sweep;
                if (r_sweep == {SET_BITS{1'b1}}) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = INIT;
                end
            end
            IDLE: begin
                if (lookup_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = CHECK;
                end else begin
                    w_next_state = IDLE;
                end
            end
            CHECK: begin
                if (w_fault) begin
                    w_stall      = 1'b1;
                    w_next_state = REQ;
                end else begin
                    if (w_hit_upd) begin
                        w_plru_we    = 1'b1;
                        w_plru_wdata = plru_touch(w_plru_cur, tag_hit_way);
                    end else begin
                        w_plru_we    = 1'b0;
                    end
                    // A hit frees the pipeline, so the next lookup is taken in this cycle.
                    if (lookup_valid) begin
                        w_accept     = 1'b1;
                        w_next_state = CHECK;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            REQ: begin
                w_stall = 1'b1;
                if (mem_ack) begin
                    w_next_state = FILL;
                end else begin
                    w_next_state = REQ;
                end
            end
            FILL: begin
                w_stall = 1'b1;
                if (mem_data_valid && (r_beat == {BEATS_LOG2{1'b1}})) begin
                    w_next_state = TAGW;
                end else begin
                    w_next_state = FILL;
                end
            end
            TAGW: begin
                w_stall      = 1'b1;
                w_plru_we    = 1'b1;
                w_plru_wdata = plru_touch(w_plru_cur, r_way);
                w_next_state = SETTLE;
            end
            SETTLE: begin
                w_stall = 1'b1;
                if (r_settle) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = SETTLE;
                end
            end
            default: begin
                w_stall      = 1'b1;
                w_next_state = INIT;
            end
        endcase
    end

    // Control state, captured lookup, victim/way, beat and miss counters.
    always_ff @(posedge main_clk) begin
        if (!main_rst_n) begin
            r_state      <= INIT;
            r_sweep      <= {SET_BITS{1'b0}};
            r_line       <= 22'd0;
            r_no_access  <= 1'b0;
            r_way        <= 2'd0;
            r_beat       <= {BEATS_LOG2{1'b0}};
            r_settle     <= 1'b0;
            r_miss_count <= 16'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == INIT) begin
                r_sweep <= r_sweep + SET_BITS'(1);
            end
            if (w_accept) begin
                r_line      <= lookup_addr[25:4];
                r_no_access <= lookup_no_access;
            end
            if (r_state == CHECK) begin
                if (w_fault) begin
                    r_way <= plru_victim(w_plru_cur);
                    if (r_miss_count != 16'hFFFF) begin
                        r_miss_count <= r_miss_count + 16'd1;
                    end
                end else begin
                    r_way <= tag_hit_way;
                end
            end
            if ((r_state == REQ) && mem_ack) begin
                r_beat <= {BEATS_LOG2{1'b0}};
            end
            if ((r_state == FILL) && mem_data_valid) begin
                r_beat <= r_beat + BEATS_LOG2'(1);
            end
            if (r_state == TAGW) begin
                r_settle <= 1'b0;
            end
            if (r_state == SETTLE) begin
                r_settle <= 1'b1;
            end
        end
    end

    // PLRU storage; cleared by the INIT sweep rather than by reset.
    always_ff @(posedge main_clk) begin
        if (main_rst_n && w_plru_we) begin
            r_plru[w_plru_waddr] <= w_plru_wdata;
        end
    end

    assign stall         = w_stall;
    assign way_index     = r_way;
    assign tag_write     = (r_state == TAGW);
    assign mem_req       = (r_state == REQ);
    assign mem_line_addr = r_line;
    assign fill_we       = (r_state == FILL) & mem_data_valid;
    assign fill_way      = r_way;
    assign fill_beat     = r_beat;
    assign miss_count    = r_miss_count;

endmodule
